anc_sample_feeder: RTL and testbench

ANC_SAMPLE_FEEDER -- requirements
Module: anc_sample_feeder

---
 rtl/anc_pkg.sv | 17 +
 rtl/anc_sync_fifo.sv | 58 +++++
 rtl/anc_sample_feeder.sv | 111 +++++++++++
 tb/tb_anc_sample_feeder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/anc_pkg.sv
// Shared ANC sample-path types: sample pair layout and feeder FSM state encoding.
package anc_pkg;

   localparam int unsigned ANC_DW = 8;

   typedef struct packed {
      logic [ANC_DW-1:0] xin;
      logic [ANC_DW-1:0] yin;
   } anc_sample_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      GAP
   } anc_feed_state_t;

endpackage

// File: rtl/anc_sync_fifo.sv
// Single-clock FIFO with occupancy counter; level tracks push/pop arithmetic, not pointer compare.
module anc_sync_fifo
   import anc_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = $bits(anc_sample_t)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [LW-1:0]    cnt;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == LW'(DEPTH));
   assign empty   = (cnt == '0);
   assign level   = cnt;
   assign rdata   = mem[rptr];
   assign do_pop  = pop && !empty;
   // A push into a full FIFO is legal when the head is leaving on the same edge.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         if (do_push && !do_pop) begin
            cnt <= cnt + 1'b1;
         end else if (do_pop && !do_push) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !rst && !flush) mem[wptr] <= wdata;
   end

endmodule

// File: rtl/anc_sample_feeder.sv
// Buffers sample pairs from a non-stallable source and feeds them to the adaptive filter as
// spaced one-cycle pulses. Define ANC_FEED_STATS_EN to add sample_cnt / drop_cnt outputs.
module anc_sample_feeder
   import anc_pkg::*;
#(
   parameter int unsigned DW    = ANC_DW,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s_vld,
   input  logic [DW-1:0]            s_xin,
   input  logic [DW-1:0]            s_yin,
   input  logic                     flush,
   input  logic                     m_rdy,
   output logic                     m_vld,
   output logic [DW-1:0]            m_xin,
   output logic [DW-1:0]            m_yin,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     ovf
`ifdef ANC_FEED_STATS_EN
   ,
   output logic [15:0]              sample_cnt,
   output logic [7:0]               drop_cnt
`endif
);

   anc_feed_state_t state;
   logic [2*DW-1:0] head;
   logic            empty;
   logic            pop;
   logic            launch;
   logic            drop;

   assign pop    = (state == ISSUE) && !flush;
   assign launch = (state == IDLE) && m_rdy && !empty;
   assign drop   = s_vld && !flush && full && !pop;

   anc_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2 * DW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (s_vld && !flush),
      .pop   (pop),
      .flush (flush),
      .wdata ({s_xin, s_yin}),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   // Head is captured on launch, so the FIFO entry can be popped later without disturbing m_xin/m_yin.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         m_vld <= 1'b0;
         m_xin <= '0;
         m_yin <= '0;
      end else if (flush) begin
         state <= IDLE;
         m_vld <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (launch) begin
                  state <= ISSUE;
                  m_vld <= 1'b1;
                  m_xin <= head[2*DW-1 -: DW];
                  m_yin <= head[DW-1:0];
               end
            end
            ISSUE: begin
               state <= GAP;
               m_vld <= 1'b0;
            end
            GAP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               m_vld <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         ovf <= 1'b0;
      end else if (drop) begin
         ovf <= 1'b1;
      end
   end

`ifdef ANC_FEED_STATS_EN
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         sample_cnt <= '0;
         drop_cnt   <= '0;
      end else begin
         if (launch) sample_cnt <= sample_cnt + 1'b1;
         if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_anc_sample_feeder.sv
// Randomised and directed bench for anc_sample_feeder against a queue-based timing model.
module tb_anc_sample_feeder;

   localparam int DW    = 8;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst, s_vld, flush, m_rdy;
   logic [DW-1:0] s_xin, s_yin;
   logic          m_vld, full, ovf;
   logic [DW-1:0] m_xin, m_yin;
   logic [3:0]    level;
`ifdef ANC_FEED_STATS_EN
   logic [15:0]   sample_cnt;
   logic [7:0]    drop_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [15:0] q[$];
   int          cool;
   bit          pend_pop;
   bit          e_vld;
   logic [7:0]  e_x, e_y;
   bit          e_ovf;
   int          e_sc, e_dc;

   always #5 clk = ~clk;

   anc_sample_feeder #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .s_vld      (s_vld),
      .s_xin      (s_xin),
      .s_yin      (s_yin),
      .flush      (flush),
      .m_rdy      (m_rdy),
      .m_vld      (m_vld),
      .m_xin      (m_xin),
      .m_yin      (m_yin),
      .full       (full),
      .level      (level),
      .ovf        (ovf)
`ifdef ANC_FEED_STATS_EN
      ,
      .sample_cnt (sample_cnt),
      .drop_cnt   (drop_cnt)
`endif
   );

   // Apply inputs for one cycle, advance the model on the edge, return 1 time unit after it.
   task automatic step(input bit v, input logic [7:0] x, input logic [7:0] y, input bit rdy,
                       input bit fl, input bit r);
      int  lvl;
      bit  popn, launch, accept;
      s_vld = v; s_xin = x; s_yin = y; m_rdy = rdy; flush = fl; rst = r;
      @(posedge clk);
      if (r) begin
         q.delete(); cool = 0; pend_pop = 0; e_vld = 0; e_x = 0; e_y = 0; e_ovf = 0;
         e_sc = 0; e_dc = 0;
      end else if (fl) begin
         q.delete(); cool = 0; pend_pop = 0; e_vld = 0; e_ovf = 0; e_sc = 0; e_dc = 0;
      end else begin
         lvl    = q.size();
         popn   = pend_pop;
         launch = (cool == 0) && !popn && rdy && (lvl > 0);
         if (launch) begin
            e_x = q[0][15:8];
            e_y = q[0][7:0];
         end
         accept = v && ((lvl < DEPTH) || popn);
         if (v && !accept) begin
            e_ovf = 1;
            if (e_dc < 255) e_dc++;
         end
         if (popn) void'(q.pop_front());
         if (accept) q.push_back({x, y});
         pend_pop = launch;
         e_vld    = launch;
         if (launch) begin
            cool = 2;
            e_sc = (e_sc + 1) % 65536;
         end else if (cool > 0) begin
            cool--;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      step(1, 8'h11, 8'h22, 1, 1, 1);
      step(1, 8'h33, 8'h44, 1, 0, 1);
      n_checks++;
      if ({m_vld, m_xin, m_yin, level, full, ovf} !== '0) begin
         n_fail++;
         $display("FAIL reset: got vld=%0b x=%0h y=%0h lvl=%0d full=%0b ovf=%0b, expected all 0",
                  m_vld, m_xin, m_yin, level, full, ovf);
      end
   endtask

   task automatic test_single();
      step(0, 0, 0, 0, 0, 1);
      step(1, 8'h8F, 8'hA8, 1, 0, 0);
      n_checks++;
      if (m_vld !== 1'b0 || level !== 4'd1) begin
         n_fail++;
         $display("FAIL single_write: got vld=%0b lvl=%0d, expected vld=0 lvl=1", m_vld, level);
      end
      step(0, 0, 0, 1, 0, 0);
      n_checks++;
      if (m_vld !== 1'b1 || m_xin !== 8'h8F || m_yin !== 8'hA8) begin
         n_fail++;
         $display("FAIL single_pulse: got vld=%0b x=%0h y=%0h, expected vld=1 x=8f y=a8",
                  m_vld, m_xin, m_yin);
      end
      step(0, 0, 0, 1, 0, 0);
      n_checks++;
      if (m_vld !== 1'b0 || level !== 4'd0 || m_xin !== 8'h8F) begin
         n_fail++;
         $display("FAIL single_after: got vld=%0b lvl=%0d x=%0h, expected vld=0 lvl=0 x=8f",
                  m_vld, level, m_xin);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] pat [4];
      int          pulse_at [$];
      logic [15:0] got [$];
      pat[0] = 16'h8FA8; pat[1] = 16'h2F48; pat[2] = 16'h8FA8; pat[3] = 16'h2F48;
      step(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 20; i++) begin
         if (i < 4) step(1, pat[i][15:8], pat[i][7:0], 1, 0, 0);
         else step(0, 0, 0, 1, 0, 0);
         if (m_vld === 1'b1) begin
            pulse_at.push_back(i);
            got.push_back({m_xin, m_yin});
         end
      end
      n_checks++;
      if (pulse_at.size() != 4) begin
         n_fail++;
         $display("FAIL burst_count: got %0d pulses, expected 4", pulse_at.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (pulse_at[i] != 1 + 3 * i || got[i] !== pat[i]) begin
               n_fail++;
               $display("FAIL burst_pulse%0d: got step %0d data %0h, expected step %0d data %0h",
                        i, pulse_at[i], got[i], 1 + 3 * i, pat[i]);
            end
         end
      end
   endtask

   task automatic test_overflow();
      int          n;
      logic [15:0] got [$];
      step(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 9; i++) step(1, 8'(i + 1), 8'(8'hF0 + i), 0, 0, 0);
      n_checks++;
      if (full !== 1'b1 || level !== 4'd8 || ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_state: got full=%0b lvl=%0d ovf=%0b, expected full=1 lvl=8 ovf=1",
                  full, level, ovf);
      end
      for (int i = 0; i < 30; i++) begin
         step(0, 0, 0, 1, 0, 0);
         if (m_vld === 1'b1) got.push_back({m_xin, m_yin});
      end
      n = got.size();
      n_checks++;
      if (n != 8 || level !== 4'd0) begin
         n_fail++;
         $display("FAIL ovf_drain: got %0d pulses lvl=%0d, expected 8 pulses lvl=0", n, level);
      end
      for (int i = 0; i < n && i < 8; i++) begin
         n_checks++;
         if (got[i] !== {8'(i + 1), 8'(8'hF0 + i)}) begin
            n_fail++;
            $display("FAIL ovf_order%0d: got %0h, expected %0h", i, got[i],
                     {8'(i + 1), 8'(8'hF0 + i)});
         end
      end
   endtask

   task automatic test_full_pop();
      step(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 8; i++) step(1, 8'(i), 8'(i), 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      n_checks++;
      if (m_vld !== 1'b1 || level !== 4'd8) begin
         n_fail++;
         $display("FAIL fullpop_issue: got vld=%0b lvl=%0d, expected vld=1 lvl=8", m_vld, level);
      end
      step(1, 8'hAA, 8'h55, 0, 0, 0);
      n_checks++;
      if (level !== 4'd8 || ovf !== 1'b0 || full !== 1'b1) begin
         n_fail++;
         $display("FAIL fullpop_write: got lvl=%0d ovf=%0b full=%0b, expected lvl=8 ovf=0 full=1",
                  level, ovf, full);
      end
   endtask

   task automatic test_flush_issue();
      int pulses = 0;
      step(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(1, 8'(i + 5), 8'(i + 9), 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      n_checks++;
      if (m_vld !== 1'b1 || level !== 4'd3) begin
         n_fail++;
         $display("FAIL flush_pre: got vld=%0b lvl=%0d, expected vld=1 lvl=3", m_vld, level);
      end
      step(1, 8'h77, 8'h66, 1, 1, 0);
      n_checks++;
      if (m_vld !== 1'b0 || level !== 4'd0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_abort: got vld=%0b lvl=%0d ovf=%0b, expected vld=0 lvl=0 ovf=0",
                  m_vld, level, ovf);
      end
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 0, 1, 0, 0);
         if (m_vld === 1'b1) pulses++;
      end
      n_checks++;
      if (pulses != 0) begin
         n_fail++;
         $display("FAIL flush_quiet: got %0d pulses, expected 0", pulses);
      end
   endtask

   task automatic test_random();
      bit v, rdy, fl, r;
      step(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 600; i++) begin
         v   = ($urandom_range(0, 9) < 6);
         rdy = ($urandom_range(0, 9) < 7);
         fl  = ($urandom_range(0, 39) == 0);
         r   = ($urandom_range(0, 149) == 0);
         step(v, 8'($urandom), 8'($urandom), rdy, fl, r);
         n_checks++;
         if (m_vld !== e_vld || m_xin !== e_x || m_yin !== e_y || level !== 4'(q.size())
             || full !== (q.size() == DEPTH) || ovf !== e_ovf) begin
            n_fail++;
            $display("FAIL random@%0d: got vld=%0b x=%0h y=%0h lvl=%0d full=%0b ovf=%0b, expected vld=%0b x=%0h y=%0h lvl=%0d full=%0b ovf=%0b",
                     i, m_vld, m_xin, m_yin, level, full, ovf, e_vld, e_x, e_y, q.size(),
                     q.size() == DEPTH, e_ovf);
         end
`ifdef ANC_FEED_STATS_EN
         n_checks++;
         if (sample_cnt !== 16'(e_sc) || drop_cnt !== 8'(e_dc)) begin
            n_fail++;
            $display("FAIL random_stats@%0d: got sc=%0d dc=%0d, expected sc=%0d dc=%0d",
                     i, sample_cnt, drop_cnt, e_sc, e_dc);
         end
`endif
      end
   endtask

`ifdef ANC_FEED_STATS_EN
   task automatic test_stats();
      step(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 10; i++) step(1, 8'(i), 8'(i), 0, 0, 0);
      for (int i = 0; i < 13; i++) step(0, 0, 0, 1, 0, 0);
      n_checks++;
      if (sample_cnt !== 16'd5 || drop_cnt !== 8'd2) begin
         n_fail++;
         $display("FAIL stats_count: got sc=%0d dc=%0d, expected sc=5 dc=2", sample_cnt, drop_cnt);
      end
      step(0, 0, 0, 0, 0, 1);
      n_checks++;
      if (sample_cnt !== 16'd0 || drop_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL stats_reset: got sc=%0d dc=%0d, expected 0 0", sample_cnt, drop_cnt);
      end
   endtask
`endif

   initial begin
      rst = 1'b1; s_vld = 1'b0; s_xin = '0; s_yin = '0; flush = 1'b0; m_rdy = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_full_pop();
      test_flush_issue();
      test_random();
`ifdef ANC_FEED_STATS_EN
      test_stats();
`else
      step(0, 0, 0, 0, 0, 1);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
